// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for a 1R/1W RAM with tagged 2-cycle read return.
// Optional power-on clear sweep when RAM_ARB_CLEAR_EN is defined.
module ram_port_arbiter #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 4,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_rdaddress,
    output logic [ADDR_W-1:0] ram_wraddress,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    logic                  run;
    logic                  clr_wr;
    logic [ADDR_W-1:0]     clr_addr;

    logic                  rr_q, rr_d;
    logic [1:0]            wr_gnt, rd_gnt;
    logic [ADDR_W-1:0]     rdaddr_q, wraddr_q;
    logic [DATA_W-1:0]     wdata_q, rdata_q;
    logic [RD_LATENCY-1:0] tok_v_q, tok_v_d;
    logic [RD_LATENCY-1:0] tok_id_q, tok_id_d;

`ifdef RAM_ARB_CLEAR_EN
    typedef enum logic [0:0] {StClear, StRun} state_e;

    localparam logic [ADDR_W:0] ClrLast = {1'b0, {ADDR_W{1'b1}}};

    state_e          state_q;
    logic [ADDR_W:0] clr_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
            busy      <= 1'b1;
        end else if (state_q == StClear) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            if (clr_cnt_q == ClrLast) begin
                state_q <= StRun;
                busy    <= 1'b0;
            end
        end
    end

    assign run      = (state_q == StRun);
    // The FSM idles in StClear during reset; keep the RAM write strobe quiet there.
    assign clr_wr   = (state_q == StClear) && reset_n;
    assign clr_addr = clr_cnt_q[ADDR_W-1:0];
`else
    // Gate on reset_n so nothing is granted while reset is held, yet grants start in the
    // very first cycle after release.
    assign run      = reset_n;
    assign clr_wr   = 1'b0;
    assign clr_addr = '0;
    assign busy     = 1'b0;
`endif

    always_comb begin
        gnt  = 2'b00;
        rr_d = rr_q;
        if (run) begin
            if (req == 2'b11) begin
                if (we[0] != we[1]) begin
                    gnt = 2'b11;
                end else begin
                    gnt  = rr_q ? 2'b10 : 2'b01;
                    rr_d = ~rr_q;
                end
            end else begin
                gnt = req;
            end
        end
    end

    assign wr_gnt = gnt & we;
    assign rd_gnt = gnt & ~we;

    always_comb begin
        ram_wren      = 1'b0;
        ram_wraddress = wraddr_q;
        ram_data      = wdata_q;
        if (clr_wr) begin
            ram_wren      = 1'b1;
            ram_wraddress = clr_addr;
            ram_data      = '0;
        end else if (wr_gnt != 2'b00) begin
            ram_wren      = 1'b1;
            ram_wraddress = wr_gnt[1] ? addr1 : addr0;
            ram_data      = wr_gnt[1] ? wdata1 : wdata0;
        end
    end

    always_comb begin
        ram_rdaddress = rdaddr_q;
        if (rd_gnt != 2'b00) begin
            ram_rdaddress = rd_gnt[1] ? addr1 : addr0;
        end
    end

    // Token pipeline tracks which requester owns the RAM output RD_LATENCY cycles later.
    always_comb begin
        tok_v_d     = '0;
        tok_id_d    = '0;
        tok_v_d[0]  = (rd_gnt != 2'b00);
        tok_id_d[0] = rd_gnt[1];
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            tok_v_d[i]  = tok_v_q[i-1];
            tok_id_d[i] = tok_id_q[i-1];
        end
    end

    always_comb begin
        rvalid = 2'b00;
        rdata  = rdata_q;
        if (tok_v_q[RD_LATENCY-1]) begin
            rvalid = tok_id_q[RD_LATENCY-1] ? 2'b10 : 2'b01;
            rdata  = ram_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q     <= 1'b0;
            rdaddr_q <= '0;
            wraddr_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            tok_v_q  <= '0;
            tok_id_q <= '0;
        end else begin
            rr_q     <= rr_d;
            rdaddr_q <= ram_rdaddress;
            wraddr_q <= ram_wraddress;
            wdata_q  <= ram_data;
            rdata_q  <= rdata;
            tok_v_q  <= tok_v_d;
            tok_id_q <= tok_id_d;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural OLD_DATA RAM and reference model.
// Honours RAM_ARB_CLEAR_EN when the design is built with it.
module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] req, we;
    logic [4:0] addr0, addr1;
    logic [3:0] wdata0, wdata1;
    logic [1:0] gnt, rvalid;
    logic [3:0] rdata;
    logic       busy;
    logic [4:0] ram_rdaddress, ram_wraddress;
    logic [3:0] ram_data;
    logic       ram_wren;
    logic [3:0] ram_q;

    ram_port_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .we           (we),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .gnt          (gnt),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .busy         (busy),
        .ram_rdaddress(ram_rdaddress),
        .ram_wraddress(ram_wraddress),
        .ram_data     (ram_data),
        .ram_wren     (ram_wren),
        .ram_q        (ram_q)
    );

    always #5 clk = ~clk;

`ifdef RAM_ARB_CLEAR_EN
    localparam bit ClearEn = 1'b1;
`else
    localparam bit ClearEn = 1'b0;
`endif

    // RAM model: registered read address, registered q, old data on read-during-write.
    logic [3:0] ram_mem [32];
    logic [3:0] rd_r;
    initial for (int i = 0; i < 32; i++) ram_mem[i] = 4'hF;
    always @(posedge clk) begin
        if (ram_wren) ram_mem[ram_wraddress] <= ram_data;
        rd_r  <= ram_mem[ram_rdaddress];
        ram_q <= rd_r;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] rv;
        logic [3:0] d;
        int         when;
    } exp_t;
    exp_t sb[$];

    logic [3:0] m_mem [32];
    bit         m_rr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents read data.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].when < cyc) begin
            e = sb.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL rvalid_missing @cyc %0d: got none expected rvalid %0h due cyc %0d",
                     cyc, e.rv, e.when);
        end
        if (rvalid != 2'b00) begin
            if (!reset_n || sb.size() == 0) begin
                chk("rvalid_unexpected", rvalid, 2'b00);
            end else begin
                e = sb.pop_front();
                chk("rvalid_id", rvalid, e.rv);
                chk("rdata", rdata, e.d);
                chk("rd_latency", cyc, e.when);
            end
        end
    end

    function automatic logic [4:0] addr_of(input int i);
        return (i == 0) ? addr0 : addr1;
    endfunction

    function automatic logic [3:0] wdata_of(input int i);
        return (i == 0) ? wdata0 : wdata1;
    endfunction

    task automatic set_op(input int i, input logic w, input logic [4:0] a, input logic [3:0] d);
        we[i] = w;
        if (i == 0) begin
            addr0  = a;
            wdata0 = d;
        end else begin
            addr1  = a;
            wdata1 = d;
        end
    endtask

    // One RUN cycle: predict the grant from the arbitration rules, record reads, apply writes.
    task automatic step(output logic [1:0] g);
        logic [1:0] eg;
        @(negedge clk);
        if (req == 2'b11 && we[0] != we[1]) begin
            eg = 2'b11;
        end else if (req == 2'b11) begin
            eg   = m_rr ? 2'b10 : 2'b01;
            m_rr = ~m_rr;
        end else begin
            eg = req;
        end
        chk("gnt", gnt, eg);
        chk("busy", busy, 1'b0);
        chk("ram_wren", ram_wren, (eg & we) != 2'b00);
        for (int i = 0; i < 2; i++)
            if (eg[i] && !we[i])
                sb.push_back('{rv: (i == 0) ? 2'b01 : 2'b10, d: m_mem[addr_of(i)],
                               when: cyc + 2});
        for (int i = 0; i < 2; i++)
            if (eg[i] && we[i]) m_mem[addr_of(i)] = wdata_of(i);
        g = eg;
        @(posedge clk);
        #1;
    endtask

    task automatic check_in_reset(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("rst_gnt", gnt, 2'b00);
            chk("rst_rvalid", rvalid, 2'b00);
            chk("rst_rdata", rdata, 4'h0);
            chk("rst_wren", ram_wren, 1'b0);
            chk("rst_busy", busy, ClearEn);
        end
    endtask

    // Called just after reset release; in clear builds the sweep must run 32 cycles first.
    task automatic after_release();
        m_rr = 1'b0;
        if (ClearEn) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 4'h0;
            for (int k = 0; k < 32; k++) begin
                @(negedge clk);
                chk("clr_busy", busy, 1'b1);
                chk("clr_gnt", gnt, 2'b00);
            end
        end
    endtask

    initial begin
        logic [1:0] g;
        bit         pend [2];

        reset_n = 1'b0;
        req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        m_rr = 1'b0;
        check_in_reset(3);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Read of the last address first: zero after a clear sweep.
        req = 2'b01;
        set_op(0, 1'b0, 5'd31, 4'h0);
        after_release();
        if (ClearEn) step(g);

        // Known contents everywhere.
        for (int a = 0; a < 32; a++) begin
            req = 2'b01;
            set_op(0, 1'b1, 5'(a), 4'($urandom_range(0, 15)));
            step(g);
        end

        // Write then read back same address.
        req = 2'b01;
        set_op(0, 1'b1, 5'd3, 4'hA);
        step(g);
        set_op(0, 1'b0, 5'd3, 4'h0);
        step(g);

        // Concurrent write and read of one address returns the old value.
        set_op(0, 1'b1, 5'd5, 4'h2);
        step(g);
        req = 2'b11;
        set_op(0, 1'b1, 5'd5, 4'h7);
        set_op(1, 1'b0, 5'd5, 4'h0);
        step(g);
        req = 2'b01;
        set_op(0, 1'b0, 5'd5, 4'h0);
        step(g);

        // Same-type conflict alternates.
        req = 2'b11;
        set_op(0, 1'b0, 5'd1, 4'h0);
        set_op(1, 1'b0, 5'd2, 4'h0);
        for (int k = 0; k < 4; k++) step(g);
        req = 2'b00;
        step(g);

        // Random traffic with hold-until-grant.
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++)
                if (!pend[i] && $urandom_range(0, 3) != 0) begin
                    pend[i] = 1'b1;
                    set_op(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                           4'($urandom_range(0, 15)));
                end
            req = {pend[1], pend[0]};
            step(g);
            for (int i = 0; i < 2; i++)
                if (g[i]) pend[i] = 1'b0;
        end

        // Read, then reset the very next cycle: token must be dropped.
        req = 2'b01;
        set_op(0, 1'b0, 5'd7, 4'h0);
        step(g);
        reset_n = 1'b0;
        sb.delete();
        check_in_reset(3);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        after_release();
        step(g);

        // Read back a handful of addresses after the reset.
        for (int a = 0; a < 8; a++) begin
            req = 2'b10;
            set_op(1, 1'b0, 5'(a * 4 + 3), 4'h0);
            step(g);
        end
        req = 2'b00;
        for (int k = 0; k < 4; k++) step(g);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
